j2_stack_unit: RTL and testbench

Register and storage stage for the j2 CPU's data and return stacks. It sits on both sides of the ALU: it supplies top-of-stack, second, return-top and both stack pointers to the ALU, and it commits the ALU's next-pointer, next-top and stack-write results on each enabled clock edge. After any reset or soft-clear request it runs a zero-fill sweep of both stack memories and signals `busy`, which the core uses as its reboot/stall condition.

---
 rtl/j2_stack_unit_pkg.sv | 38 +++
 rtl/j2_stack_unit_stack_ram.sv | 24 ++
 rtl/j2_stack_unit.sv | 146 ++++++++++++++
 tb/tb_j2_stack_unit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/j2_stack_unit_pkg.sv
// Shared sizes, state encoding and pointer-wrap helpers for the j2 data/return stack unit.
package j2_stack_unit_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    typedef logic [DEPTH-1:0] ptr_t;
    typedef logic [WIDTH-1:0] cell_t;

    localparam ptr_t PtrMax = '1;

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } stk_state_e;

    typedef struct packed {
        logic data_overflow;
        logic data_underflow;
        logic return_overflow;
        logic return_underflow;
    } stk_flags_t;

    // Step of +1 out of the top slot.
    function automatic logic ptr_overflow(input ptr_t cur, input ptr_t nxt);
        ptr_t delta;
        delta = nxt - cur;
        return (delta == ptr_t'(1)) && (cur == PtrMax);
    endfunction

    // Step of -1 out of the bottom slot.
    function automatic logic ptr_underflow(input ptr_t cur, input ptr_t nxt);
        ptr_t delta;
        delta = nxt - cur;
        return (delta == PtrMax) && (cur == '0);
    endfunction

endpackage

// File: rtl/j2_stack_unit_stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port, no reset.
module j2_stack_unit_stack_ram #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [Depth-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [Depth-1:0] raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem [2**Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/j2_stack_unit.sv
// Data/return stack registers and memories for the j2 core, with a zero-fill sweep after reset
// or a clear request.
module j2_stack_unit
    import j2_stack_unit_pkg::*;
(
    input  logic             clk,
    input  logic             resetq,
    input  logic             enable,
    input  logic             clear_request,
    input  logic [DEPTH-1:0] data_stack_pointer_second,
    input  logic [WIDTH-1:0] data_stack_next_top,
    input  logic             data_stack_write_enable,
    input  logic [DEPTH-1:0] return_stack_pointer_second,
    input  logic [WIDTH-1:0] return_stack_second,
    input  logic             return_stack_write_enable,
    output logic [DEPTH-1:0] data_stack_pointer_top,
    output logic [WIDTH-1:0] data_stack_top,
    output logic [WIDTH-1:0] data_stack_second,
    output logic [DEPTH-1:0] return_stack_pointer_top,
    output logic [WIDTH-1:0] return_stack_top,
    output logic             busy,
    output logic             data_overflow,
    output logic             data_underflow,
    output logic             return_overflow,
    output logic             return_underflow
);

    stk_state_e state_q, state_d;
    ptr_t       sweep_q, sweep_d;
    ptr_t       dsp_q, dsp_d;
    ptr_t       rsp_q, rsp_d;
    cell_t      t_q, t_d;
    stk_flags_t flags_q, flags_d;

    logic  commit;
    logic  clearing;
    logic  dram_we, rram_we;
    ptr_t  dram_addr, rram_addr;
    cell_t dram_wdata, rram_wdata;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= StClear;
            sweep_q <= '0;
            dsp_q   <= '0;
            rsp_q   <= '0;
            t_q     <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            dsp_q   <= dsp_d;
            rsp_q   <= rsp_d;
            t_q     <= t_d;
            flags_q <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        dsp_d   = dsp_q;
        rsp_d   = rsp_q;
        t_d     = t_q;
        flags_d = flags_q;
        commit  = 1'b0;
        unique case (state_q)
            StClear: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == PtrMax) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // A clear request wins over enable: nothing commits on that edge.
                if (clear_request) begin
                    state_d = StClear;
                    sweep_d = '0;
                    dsp_d   = '0;
                    rsp_d   = '0;
                    t_d     = '0;
                    flags_d = '0;
                end else if (enable) begin
                    commit  = 1'b1;
                    dsp_d   = data_stack_pointer_second;
                    t_d     = data_stack_next_top;
                    rsp_d   = return_stack_pointer_second;
                    flags_d.data_overflow    = flags_q.data_overflow
                        | ptr_overflow(dsp_q, data_stack_pointer_second);
                    flags_d.data_underflow   = flags_q.data_underflow
                        | ptr_underflow(dsp_q, data_stack_pointer_second);
                    flags_d.return_overflow  = flags_q.return_overflow
                        | ptr_overflow(rsp_q, return_stack_pointer_second);
                    flags_d.return_underflow = flags_q.return_underflow
                        | ptr_underflow(rsp_q, return_stack_pointer_second);
                end
            end
            default: state_d = StClear;
        endcase
    end

    // The sweep shares each memory's only write port with the normal commit path.
    always_comb begin
        clearing   = (state_q == StClear);
        dram_we    = clearing | (commit & data_stack_write_enable);
        dram_addr  = clearing ? sweep_q : data_stack_pointer_second;
        dram_wdata = clearing ? '0 : t_q;
        rram_we    = clearing | (commit & return_stack_write_enable);
        rram_addr  = clearing ? sweep_q : return_stack_pointer_second;
        rram_wdata = clearing ? '0 : return_stack_second;
    end

    j2_stack_unit_stack_ram #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) u_data_ram (
        .clk   (clk),
        .we    (dram_we),
        .waddr (dram_addr),
        .wdata (dram_wdata),
        .raddr (dsp_q),
        .rdata (data_stack_second)
    );

    j2_stack_unit_stack_ram #(
        .Width (WIDTH),
        .Depth (DEPTH)
    ) u_return_ram (
        .clk   (clk),
        .we    (rram_we),
        .waddr (rram_addr),
        .wdata (rram_wdata),
        .raddr (rsp_q),
        .rdata (return_stack_top)
    );

    assign busy                     = clearing;
    assign data_stack_pointer_top   = dsp_q;
    assign data_stack_top           = t_q;
    assign return_stack_pointer_top = rsp_q;
    assign data_overflow            = flags_q.data_overflow;
    assign data_underflow           = flags_q.data_underflow;
    assign return_overflow          = flags_q.return_overflow;
    assign return_underflow         = flags_q.return_underflow;

endmodule

// File: tb/tb_j2_stack_unit.sv
// Self-checking bench for j2_stack_unit: directed table, sweep/reset sequences, random vs model.
module tb_j2_stack_unit;

    logic        clk;
    logic        resetq;
    logic        enable;
    logic        clear_request;
    logic [3:0]  dsp_second;
    logic [31:0] next_top;
    logic        dwe;
    logic [3:0]  rsp_second;
    logic [31:0] rs_second;
    logic        rwe;
    logic [3:0]  dsp_out;
    logic [31:0] t_out;
    logic [31:0] n_out;
    logic [3:0]  rsp_out;
    logic [31:0] r_out;
    logic        busy;
    logic        d_ov, d_un, r_ov, r_un;

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays and integers.
    logic [31:0] m_dmem [16];
    logic [31:0] m_rmem [16];
    logic [31:0] m_t;
    int          m_dsp, m_rsp;
    logic [3:0]  m_flags;   // {d_ov, d_un, r_ov, r_un}
    int          m_busy_left;

    typedef struct {
        logic        en;
        logic        clr;
        logic [3:0]  dsp_n;
        logic [31:0] ntop;
        logic        dwe;
        logic [3:0]  rsp_n;
        logic [31:0] rsec;
        logic        rwe;
        logic [3:0]  e_dsp;
        logic [31:0] e_t;
        logic [31:0] e_n;
        logic [3:0]  e_rsp;
        logic [31:0] e_r;
        logic [3:0]  e_flags;
        logic        e_busy;
    } vec_t;

    vec_t vecs [13];

    j2_stack_unit dut (
        .clk                         (clk),
        .resetq                      (resetq),
        .enable                      (enable),
        .clear_request               (clear_request),
        .data_stack_pointer_second   (dsp_second),
        .data_stack_next_top         (next_top),
        .data_stack_write_enable     (dwe),
        .return_stack_pointer_second (rsp_second),
        .return_stack_second         (rs_second),
        .return_stack_write_enable   (rwe),
        .data_stack_pointer_top      (dsp_out),
        .data_stack_top              (t_out),
        .data_stack_second           (n_out),
        .return_stack_pointer_top    (rsp_out),
        .return_stack_top            (r_out),
        .busy                        (busy),
        .data_overflow               (d_ov),
        .data_underflow              (d_un),
        .return_overflow             (r_ov),
        .return_underflow            (r_un)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy_left = 16;
        m_t         = '0;
        m_dsp       = 0;
        m_rsp       = 0;
        m_flags     = '0;
    endtask

    task automatic model_edge();
        int dd, rd;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                for (int i = 0; i < 16; i++) begin
                    m_dmem[i] = '0;
                    m_rmem[i] = '0;
                end
            end
        end else if (clear_request) begin
            model_reset();
        end else if (enable) begin
            dd = (int'(dsp_second) - m_dsp + 16) % 16;
            rd = (int'(rsp_second) - m_rsp + 16) % 16;
            if (dd == 1 && m_dsp == 15) m_flags[3] = 1'b1;
            if (dd == 15 && m_dsp == 0) m_flags[2] = 1'b1;
            if (rd == 1 && m_rsp == 15) m_flags[1] = 1'b1;
            if (rd == 15 && m_rsp == 0) m_flags[0] = 1'b1;
            if (dwe) m_dmem[dsp_second] = m_t;
            if (rwe) m_rmem[rsp_second] = rs_second;
            m_dsp = int'(dsp_second);
            m_rsp = int'(rsp_second);
            m_t   = next_top;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (resetq) model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, m_busy_left > 0});
        check({tag, ".dsp"}, {28'd0, dsp_out}, 32'(m_dsp));
        check({tag, ".rsp"}, {28'd0, rsp_out}, 32'(m_rsp));
        check({tag, ".T"}, t_out, m_t);
        check({tag, ".flags"}, {28'd0, d_ov, d_un, r_ov, r_un}, {28'd0, m_flags});
        if (m_busy_left == 0) begin
            check({tag, ".N"}, n_out, m_dmem[m_dsp]);
            check({tag, ".R"}, r_out, m_rmem[m_rsp]);
        end
    endtask

    task automatic idle_inputs();
        enable        = 1'b0;
        clear_request = 1'b0;
        dsp_second    = '0;
        next_top      = '0;
        dwe           = 1'b0;
        rsp_second    = '0;
        rs_second     = '0;
        rwe           = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int nd;
        vec_t v;

        vecs[0]  = '{1'b1, 1'b0, 4'd1, 32'h1234, 1'b1, 4'd0, 32'h0, 1'b0,
                     4'd1, 32'h1234, 32'h0, 4'd0, 32'h0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 4'd1, 32'h1234, 1'b0, 4'd1, 32'h42, 1'b1,
                     4'd1, 32'h1234, 32'h0, 4'd1, 32'h42, 4'b0000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 4'd1, 32'h1234, 1'b0, 4'd0, 32'h0, 1'b0,
                     4'd1, 32'h1234, 32'h0, 4'd0, 32'h0, 4'b0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 4'd2, 32'hBEEF, 1'b1, 4'd0, 32'h0, 1'b0,
                     4'd2, 32'hBEEF, 32'h1234, 4'd0, 32'h0, 4'b0000, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 4'd7, 32'hFFFF, 1'b1, 4'd5, 32'hDEAD, 1'b1,
                     4'd2, 32'hBEEF, 32'h1234, 4'd0, 32'h0, 4'b0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 4'd1, 32'h1234, 1'b0, 4'd0, 32'h0, 1'b0,
                     4'd1, 32'h1234, 32'h0, 4'd0, 32'h0, 4'b0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b0,
                     4'd0, 32'h0, 32'h0, 4'd0, 32'h0, 4'b0000, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 4'd15, 32'h5, 1'b1, 4'd0, 32'h0, 1'b0,
                     4'd15, 32'h5, 32'h0, 4'd0, 32'h0, 4'b0100, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 4'd0, 32'h6, 1'b1, 4'd0, 32'h0, 1'b0,
                     4'd0, 32'h6, 32'h5, 4'd0, 32'h0, 4'b1100, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 4'd0, 32'h6, 1'b0, 4'd15, 32'h77, 1'b1,
                     4'd0, 32'h6, 32'h5, 4'd15, 32'h77, 4'b1101, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 4'd0, 32'h6, 1'b0, 4'd0, 32'h0, 1'b0,
                     4'd0, 32'h6, 32'h5, 4'd0, 32'h0, 4'b1111, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'd1, 32'h7, 1'b0, 4'd1, 32'h0, 1'b0,
                     4'd1, 32'h7, 32'h0, 4'd1, 32'h42, 4'b1111, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'd3, 32'hFFFF, 1'b1, 4'd0, 32'h0, 1'b0,
                     4'd0, 32'h0, 32'h0, 4'd0, 32'h0, 4'b0000, 1'b1};

        idle_inputs();
        resetq = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            m_dmem[i] = '0;
            m_rmem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy", {31'd0, busy}, 32'd1);
        check("reset.dsp", {28'd0, dsp_out}, 32'd0);
        check("reset.T", t_out, 32'd0);
        check_model("reset");

        @(negedge clk) resetq = 1'b1;
        count_busy(n);
        check("sweep_len", 32'(n), 32'd16);
        check_model("after_sweep");

        // Fill both stacks with junk so the next sweep has something to erase.
        for (int i = 0; i < 16; i++) begin
            enable     = 1'b1;
            dsp_second = 4'(i);
            next_top   = $urandom;
            dwe        = 1'b1;
            rsp_second = 4'(i);
            rs_second  = $urandom;
            rwe        = 1'b1;
            step();
            check_model("preload");
        end

        @(negedge clk) resetq = 1'b0;
        idle_inputs();
        model_reset();
        #1;
        check("pulse.busy", {31'd0, busy}, 32'd1);
        check("pulse.dsp", {28'd0, dsp_out}, 32'd0);
        check("pulse.rsp", {28'd0, rsp_out}, 32'd0);
        @(negedge clk) resetq = 1'b1;
        count_busy(n);
        check("resweep_len", 32'(n), 32'd16);

        for (int i = 0; i < 16; i++) begin
            enable     = 1'b1;
            dsp_second = 4'(i);
            rsp_second = 4'(i);
            step();
            check("swept.N", n_out, 32'd0);
            check("swept.R", r_out, 32'd0);
            check("swept.T", t_out, 32'd0);
        end

        // Clear request held into the sweep must not restart it.
        idle_inputs();
        clear_request = 1'b1;
        step();
        check("clr.busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            clear_request = (n < 5);
            step();
            n++;
        end
        check("clr_sweep_len", 32'(n), 32'd16);
        idle_inputs();

        for (int k = 0; k < 13; k++) begin
            v             = vecs[k];
            enable        = v.en;
            clear_request = v.clr;
            dsp_second    = v.dsp_n;
            next_top      = v.ntop;
            dwe           = v.dwe;
            rsp_second    = v.rsp_n;
            rs_second     = v.rsec;
            rwe           = v.rwe;
            step();
            check($sformatf("vec%0d.busy", k), {31'd0, busy}, {31'd0, v.e_busy});
            check($sformatf("vec%0d.dsp", k), {28'd0, dsp_out}, {28'd0, v.e_dsp});
            check($sformatf("vec%0d.T", k), t_out, v.e_t);
            check($sformatf("vec%0d.rsp", k), {28'd0, rsp_out}, {28'd0, v.e_rsp});
            check($sformatf("vec%0d.flags", k), {28'd0, d_ov, d_un, r_ov, r_un},
                  {28'd0, v.e_flags});
            if (!v.e_busy) begin
                check($sformatf("vec%0d.N", k), n_out, v.e_n);
                check($sformatf("vec%0d.R", k), r_out, v.e_r);
            end
        end

        // Reset in the middle of the sweep started by the last vector.
        idle_inputs();
        repeat (7) step();
        check("mid.busy_before", {31'd0, busy}, 32'd1);
        resetq = 1'b0;
        model_reset();
        #1;
        check("mid.busy", {31'd0, busy}, 32'd1);
        @(negedge clk) resetq = 1'b1;
        count_busy(n);
        check("mid_sweep_len", 32'(n), 32'd16);
        check_model("mid_done");

        for (int c = 0; c < 400; c++) begin
            enable        = ($urandom_range(0, 3) != 0);
            clear_request = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 7) == 0) nd = int'($urandom_range(0, 15));
            else nd = (m_dsp + int'($urandom_range(0, 2)) + 15) % 16;
            dsp_second = 4'(nd);
            if ($urandom_range(0, 7) == 0) nd = int'($urandom_range(0, 15));
            else nd = (m_rsp + int'($urandom_range(0, 2)) + 15) % 16;
            rsp_second = 4'(nd);
            next_top   = $urandom;
            rs_second  = $urandom;
            dwe        = $urandom_range(0, 1) == 1;
            rwe        = $urandom_range(0, 1) == 1;
            step();
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
